vm80a_sysctl: RTL and testbench

//  System controller for the vm80a core (8224/8228 equivalent). Generates the
//  f1/f2 phase enables from pin_clk and latches the status byte during SYNC.

---
 rtl/vm80a_sysctl_pkg.sv | 57 +++++
 rtl/vm80a_sysctl_if.sv | 59 +++++
 rtl/vm80a_phase_gen.sv | 53 +++++
 rtl/vm80a_sysctl.sv | 155 +++++++++++++++
 tb/tb_vm80a_sysctl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vm80a_sysctl_pkg.sv
// ----------------------------------------------------------------------------
// vm80a_sysctl_pkg
//
// Shared definitions for the vm80a system controller:
//   - status byte bit indices (the byte the CPU puts on D[7:0] during SYNC)
//   - HOLD/HLDA arbiter state encoding (2-bit)
//   - cycle classification / wait-state load helpers
// ----------------------------------------------------------------------------
package vm80a_sysctl_pkg;

    // Status byte bit positions
    localparam int ST_INTA  = 0;
    localparam int ST_WO_N  = 1;
    localparam int ST_STACK = 2;
    localparam int ST_HLTA  = 3;
    localparam int ST_OUT   = 4;
    localparam int ST_M1    = 5;
    localparam int ST_INP   = 6;
    localparam int ST_MEMR  = 7;

    // Bus arbitration between the CPU and the single DMA requester
    typedef enum logic [1:0] {
        HOLD_IDLE = 2'd0,
        HOLD_REQ  = 2'd1,
        HOLD_GNT  = 2'd2,
        HOLD_REL  = 2'd3
    } hold_state_t;

    // A cycle touches memory when it reads memory, or when it is a write
    // (WO_n low) that is neither OUT nor INTA/HLTA.
    function automatic logic is_mem_cycle(input logic [7:0] st);
        return st[ST_MEMR] |
               (~st[ST_WO_N] & ~st[ST_OUT] & ~st[ST_INTA] & ~st[ST_HLTA]);
    endfunction

    function automatic logic is_io_cycle(input logic [7:0] st);
        return st[ST_INP] | st[ST_OUT];
    endfunction

    // Wait count loaded when a new status byte is latched. INTA and HLTA
    // take precedence: HLTA also carries MEMR, but a halt must never stall.
    function automatic logic [2:0] wait_load(input logic [7:0] st,
                                             input logic [2:0] wait_mem,
                                             input logic [2:0] wait_io);
        logic [2:0] w;
        w = 3'd0;
        if (st[ST_INTA] | st[ST_HLTA]) begin
            w = 3'd0;
        end else if (is_mem_cycle(st)) begin
            w = wait_mem;
        end else if (is_io_cycle(st)) begin
            w = wait_io;
        end
        return w;
    endfunction

endpackage

// File: rtl/vm80a_sysctl_if.sv
// ----------------------------------------------------------------------------
// vm80a_sysctl_if
//
// Bundles every signal of the system controller except clock and reset.
//   master : the controller's view (drives phases, strobes, HOLD, READY...)
//   slave  : the CPU / memory / DMA side view (drives D, SYNC, DBIN, WR#...)
//
// Signals:
//   pin_f1, pin_f2          phase enables to the CPU
//   pin_d[7:0]              CPU data bus, status byte during SYNC
//   pin_sync, pin_dbin      CPU SYNC and DBIN
//   pin_wr_n, pin_hlda      CPU WR# and HLDA
//   pin_hold, pin_ready     HOLD and READY to the CPU
//   ext_ready               slow-device ready, ANDed into READY
//   memr_n, memw_n          memory strobes
//   ior_n, iow_n            IO strobes
//   inta_n                  interrupt acknowledge strobe
//   vec_d[7:0], vec_oe      RST opcode and its output enable
//   stat[7:0]               latched status byte
//   dma_req, dma_gnt        DMA request (level) and grant
// ----------------------------------------------------------------------------
interface vm80a_sysctl_if;

    logic       pin_f1;
    logic       pin_f2;
    logic [7:0] pin_d;
    logic       pin_sync;
    logic       pin_dbin;
    logic       pin_wr_n;
    logic       pin_hlda;
    logic       pin_hold;
    logic       pin_ready;
    logic       ext_ready;
    logic       memr_n;
    logic       memw_n;
    logic       ior_n;
    logic       iow_n;
    logic       inta_n;
    logic [7:0] vec_d;
    logic       vec_oe;
    logic [7:0] stat;
    logic       dma_req;
    logic       dma_gnt;

    modport master (
        input  pin_d, pin_sync, pin_dbin, pin_wr_n, pin_hlda, ext_ready, dma_req,
        output pin_f1, pin_f2, pin_hold, pin_ready,
               memr_n, memw_n, ior_n, iow_n, inta_n,
               vec_d, vec_oe, stat, dma_gnt
    );

    modport slave (
        output pin_d, pin_sync, pin_dbin, pin_wr_n, pin_hlda, ext_ready, dma_req,
        input  pin_f1, pin_f2, pin_hold, pin_ready,
               memr_n, memw_n, ior_n, iow_n, inta_n,
               vec_d, vec_oe, stat, dma_gnt
    );

endinterface

// File: rtl/vm80a_phase_gen.sv
// ----------------------------------------------------------------------------
// vm80a_phase_gen
//
// Two-phase clock enable generator. A free-running counter c walks 0..P-1
// with P = F1_CLK + F2_CLK + F0_CLK and wraps without ever stalling.
//
// Ports:
//   pin_clk      in   master clock (rising edge)
//   pin_reset_n  in   synchronous reset, active low
//   pin_f1       out  registered, high for c < F1_CLK
//   pin_f2       out  registered, high for F1_CLK <= c < F1_CLK+F2_CLK
//   end_f2       out  one-clock strobe, high while c is the last f2 count
// ----------------------------------------------------------------------------
module vm80a_phase_gen #(
    parameter int F1_CLK = 2,
    parameter int F2_CLK = 3,
    parameter int F0_CLK = 4
) (
    input  logic pin_clk,
    input  logic pin_reset_n,
    output logic pin_f1,
    output logic pin_f2,
    output logic end_f2
);

    localparam int PERIOD = F1_CLK + F2_CLK + F0_CLK;
    // One spare code so F1_CLK+F2_CLK is representable even when F0_CLK=0
    localparam int CW     = $clog2(PERIOD + 1);

    localparam logic [CW-1:0] C_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] C_F1     = CW'(F1_CLK);
    localparam logic [CW-1:0] C_F12    = CW'(F1_CLK + F2_CLK);
    localparam logic [CW-1:0] C_F2_END = CW'(F1_CLK + F2_CLK - 1);

    logic [CW-1:0] cnt;

    // Outputs are decoded from the count before it advances, so with c=0
    // held in reset the very first edge after release raises f1.
    always_ff @(posedge pin_clk) begin
        if (!pin_reset_n) begin
            cnt    <= '0;
            pin_f1 <= 1'b0;
            pin_f2 <= 1'b0;
        end else begin
            cnt    <= (cnt == C_LAST) ? '0 : cnt + CW'(1);
            pin_f1 <= (cnt < C_F1);
            pin_f2 <= (cnt >= C_F1) && (cnt < C_F12);
        end
    end

    assign end_f2 = (cnt == C_F2_END);

endmodule

// File: rtl/vm80a_sysctl.sv
// ----------------------------------------------------------------------------
// vm80a_sysctl
//
// System controller for the vm80a core (8224/8228 equivalent): phase
// generation, status latch, bus strobe decode, wait-state insertion, RST
// vector on INTA and HOLD/HLDA arbitration for one DMA requester.
//
// Ports:
//   pin_clk      in   master clock, all state on rising edge
//   pin_reset_n  in   synchronous reset, active low
//   bus          vm80a_sysctl_if.master, all CPU/memory/DMA signals
//
// Parameters:
//   F1_CLK/F2_CLK/F0_CLK  clocks per f1, per f2, and with both phases low
//   WAIT_MEM/WAIT_IO      wait states for memory and IO cycles (0..7)
//   RST_VEC               opcode returned on interrupt acknowledge
// ----------------------------------------------------------------------------
module vm80a_sysctl
    import vm80a_sysctl_pkg::*;
#(
    parameter int         F1_CLK   = 2,
    parameter int         F2_CLK   = 3,
    parameter int         F0_CLK   = 4,
    parameter int         WAIT_MEM = 0,
    parameter int         WAIT_IO  = 1,
    parameter logic [7:0] RST_VEC  = 8'hE7
) (
    input  logic                  pin_clk,
    input  logic                  pin_reset_n,
    vm80a_sysctl_if.master        bus
);

    logic        f1;
    logic        f2;
    logic        end_f2;
    logic [7:0]  stat_q;
    logic [2:0]  wcnt_q;
    hold_state_t state_q;
    hold_state_t state_d;
    logic        hold;
    logic        gnt;
    logic        memr_n;
    logic        memw_n;
    logic        ior_n;
    logic        iow_n;
    logic        inta_n;

    vm80a_phase_gen #(
        .F1_CLK (F1_CLK),
        .F2_CLK (F2_CLK),
        .F0_CLK (F0_CLK)
    ) u_phase_gen (
        .pin_clk     (pin_clk),
        .pin_reset_n (pin_reset_n),
        .pin_f1      (f1),
        .pin_f2      (f2),
        .end_f2      (end_f2)
    );

    // Status byte and wait counter both change only on the last f2 clock.
    // A fresh SYNC reloads the counter; otherwise it counts down to zero.
    always_ff @(posedge pin_clk) begin
        if (!pin_reset_n) begin
            stat_q <= 8'h00;
            wcnt_q <= 3'd0;
        end else if (end_f2) begin
            if (bus.pin_sync) begin
                stat_q <= bus.pin_d;
                wcnt_q <= wait_load(bus.pin_d, 3'(WAIT_MEM), 3'(WAIT_IO));
            end else if (wcnt_q != 3'd0) begin
                wcnt_q <= wcnt_q - 3'd1;
            end
        end
    end

    // Strobe decode. While the CPU has handed the bus over (HLDA) none of
    // its strobes may reach memory or IO.
    always_comb begin
        memr_n = 1'b1;
        memw_n = 1'b1;
        ior_n  = 1'b1;
        iow_n  = 1'b1;
        inta_n = 1'b1;
        if (!bus.pin_hlda) begin
            memr_n = ~(stat_q[ST_MEMR] & bus.pin_dbin);
            ior_n  = ~(stat_q[ST_INP]  & bus.pin_dbin);
            inta_n = ~(stat_q[ST_INTA] & bus.pin_dbin);
            memw_n = ~(~stat_q[ST_OUT] & ~stat_q[ST_WO_N] & ~bus.pin_wr_n);
            iow_n  = ~(stat_q[ST_OUT]  & ~bus.pin_wr_n);
        end
    end

    // HOLD arbiter state register
    always_ff @(posedge pin_clk) begin
        if (!pin_reset_n) begin
            state_q <= HOLD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD arbiter next state and outputs. In REQ a withdrawn request wins
    // over an arriving HLDA. REL waits for HLDA to drop before any new
    // request is looked at, so the CPU always regains the bus in between.
    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        gnt     = 1'b0;
        case (state_q)
            HOLD_IDLE: begin
                if (bus.dma_req) begin
                    state_d = HOLD_REQ;
                end
            end
            HOLD_REQ: begin
                hold = 1'b1;
                if (!bus.dma_req) begin
                    state_d = HOLD_IDLE;
                end else if (bus.pin_hlda) begin
                    state_d = HOLD_GNT;
                end
            end
            HOLD_GNT: begin
                hold = 1'b1;
                gnt  = 1'b1;
                if (!bus.dma_req) begin
                    state_d = HOLD_REL;
                end
            end
            HOLD_REL: begin
                if (!bus.pin_hlda) begin
                    state_d = HOLD_IDLE;
                end
            end
            default: begin
                state_d = HOLD_IDLE;
            end
        endcase
    end

    assign bus.pin_f1    = f1;
    assign bus.pin_f2    = f2;
    assign bus.stat      = stat_q;
    assign bus.pin_ready = (wcnt_q == 3'd0) & bus.ext_ready;
    assign bus.memr_n    = memr_n;
    assign bus.memw_n    = memw_n;
    assign bus.ior_n     = ior_n;
    assign bus.iow_n     = iow_n;
    assign bus.inta_n    = inta_n;
    assign bus.vec_oe    = ~inta_n;
    assign bus.vec_d     = RST_VEC;
    assign bus.pin_hold  = hold;
    assign bus.dma_gnt   = gnt;

endmodule

// File: tb/tb_vm80a_sysctl.sv
// ----------------------------------------------------------------------------
// tb_vm80a_sysctl
//
// Self-checking bench for vm80a_sysctl with default parameters
// (F1=2, F2=3, F0=4 -> period 9, WAIT_MEM=0, WAIT_IO=1, RST_VEC=E7).
// ----------------------------------------------------------------------------
module tb_vm80a_sysctl;

    localparam int P_TB   = 9;
    localparam int F1_TB  = 2;
    localparam int F12_TB = 5;
    localparam int END_C  = 4;

    logic pin_clk;
    logic pin_reset_n;
    int   n_cmp;
    int   n_fail;
    int   edge_idx;

    vm80a_sysctl_if bus ();

    vm80a_sysctl dut (
        .pin_clk     (pin_clk),
        .pin_reset_n (pin_reset_n),
        .bus         (bus)
    );

    initial pin_clk = 1'b0;
    always #5 pin_clk = ~pin_clk;

    // Strobe bundle order: {memr_n, memw_n, ior_n, iow_n, inta_n}
    typedef struct {
        string      name;
        logic [7:0] d;
        logic       dbin;
        logic       wr_n;
        logic       hlda;
        logic       ext_rdy;
        logic [4:0] exp_strb;
        logic       exp_oe;
        logic       exp_rdy;
    } vec_t;

    vec_t vecs[10];

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge pin_clk);
        if (pin_reset_n) edge_idx++;
        else             edge_idx = 0;
        #1;
    endtask

    function automatic bit at_end_edge();
        return (edge_idx > 0) && (((edge_idx - 1) % P_TB) == END_C);
    endfunction

    // Present a status byte with SYNC until the last-f2 edge has latched it.
    task automatic load_status(input logic [7:0] d);
        bit found;
        found = 1'b0;
        bus.pin_d    = d;
        bus.pin_sync = 1'b1;
        for (int i = 0; i < 2 * P_TB; i++) begin
            step();
            if (at_end_edge()) begin
                found = 1'b1;
                break;
            end
        end
        bus.pin_sync = 1'b0;
        bus.pin_d    = 8'hFF;
        if (!found) check_output("end_edge_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.pin_dbin  = v.dbin;
        bus.pin_wr_n  = v.wr_n;
        bus.pin_hlda  = v.hlda;
        bus.ext_ready = v.ext_rdy;
    endtask

    task automatic idle_inputs();
        bus.pin_dbin  = 1'b0;
        bus.pin_wr_n  = 1'b1;
        bus.pin_hlda  = 1'b0;
        bus.ext_ready = 1'b1;
    endtask

    function automatic logic [4:0] strobes();
        return {bus.memr_n, bus.memw_n, bus.ior_n, bus.iow_n, bus.inta_n};
    endfunction

    task automatic check_reset_state(input string tag);
        check_output({tag, ".f1f2"},   {30'd0, bus.pin_f1, bus.pin_f2}, 32'd0);
        check_output({tag, ".stat"},   {24'd0, bus.stat}, 32'h00);
        check_output({tag, ".ready"},  {31'd0, bus.pin_ready}, 32'd1);
        check_output({tag, ".strb"},   {27'd0, strobes()}, 32'h1F);
        check_output({tag, ".vec_oe"}, {31'd0, bus.vec_oe}, 32'd0);
        check_output({tag, ".hold"},   {31'd0, bus.pin_hold}, 32'd0);
        check_output({tag, ".gnt"},    {31'd0, bus.dma_gnt}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        edge_idx = 0;

        vecs[0] = '{"m1_fetch",   8'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 5'b01111, 1'b0, 1'b1};
        vecs[1] = '{"in_read",    8'h42, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11011, 1'b0, 1'b0};
        vecs[2] = '{"inta",       8'h23, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11110, 1'b1, 1'b1};
        vecs[3] = '{"mem_write",  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10111, 1'b0, 1'b1};
        vecs[4] = '{"out_write",  8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11101, 1'b0, 1'b0};
        vecs[5] = '{"stack_hlda", 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b1};
        vecs[6] = '{"memr_slow",  8'h82, 1'b1, 1'b1, 1'b0, 1'b0, 5'b01111, 1'b0, 1'b0};
        vecs[7] = '{"halt",       8'h8A, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11111, 1'b0, 1'b1};
        vecs[8] = '{"in_hlda",    8'h42, 1'b1, 1'b1, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b0};
        vecs[9] = '{"fetch_idle", 8'hA2, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11111, 1'b0, 1'b1};

        // Reset held three clocks
        pin_reset_n  = 1'b0;
        bus.pin_d    = 8'h00;
        bus.pin_sync = 1'b0;
        bus.dma_req  = 1'b0;
        idle_inputs();
        repeat (3) step();
        check_reset_state("reset");

        // Phase pattern: two periods after release
        pin_reset_n = 1'b1;
        for (int k = 0; k < 2 * P_TB; k++) begin
            int c;
            step();
            c = (edge_idx - 1) % P_TB;
            check_output($sformatf("phase.e%0d", edge_idx),
                         {30'd0, bus.pin_f1, bus.pin_f2},
                         {30'd0, 1'(c < F1_TB), 1'((c >= F1_TB) && (c < F12_TB))});
        end

        // Decode table
        foreach (vecs[i]) begin
            idle_inputs();
            load_status(vecs[i].d);
            apply_stimulus(vecs[i]);
            #1;
            check_output({vecs[i].name, ".stat"},  {24'd0, bus.stat}, {24'd0, vecs[i].d});
            check_output({vecs[i].name, ".strb"},  {27'd0, strobes()}, {27'd0, vecs[i].exp_strb});
            check_output({vecs[i].name, ".oe"},    {31'd0, bus.vec_oe}, {31'd0, vecs[i].exp_oe});
            check_output({vecs[i].name, ".ready"}, {31'd0, bus.pin_ready}, {31'd0, vecs[i].exp_rdy});
            if (vecs[i].exp_oe)
                check_output({vecs[i].name, ".vec_d"}, {24'd0, bus.vec_d}, 32'hE7);
        end
        idle_inputs();

        // IO wait state: READY low for exactly one phase period
        load_status(8'h42);
        bus.pin_dbin = 1'b1;
        #1;
        check_output("io_wait.ior_n", {31'd0, bus.ior_n}, 32'd0);
        for (int i = 0; i < P_TB; i++) begin
            check_output($sformatf("io_wait.low%0d", i), {31'd0, bus.pin_ready}, 32'd0);
            step();
        end
        check_output("io_wait.release", {31'd0, bus.pin_ready}, 32'd1);

        // HOLD/HLDA handshake (status 42 still latched, DBIN high)
        bus.dma_req = 1'b1;
        step();
        check_output("hold.req", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b10);
        repeat (2) step();
        check_output("hold.req_wait", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b10);
        bus.pin_hlda = 1'b1;
        bus.pin_wr_n = 1'b0;
        step();
        check_output("hold.gnt", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b11);
        check_output("hold.gnt_strb", {27'd0, strobes()}, 32'h1F);
        bus.pin_wr_n = 1'b1;
        bus.dma_req  = 1'b0;
        step();
        check_output("hold.rel", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b00);
        bus.dma_req = 1'b1;
        step();
        check_output("hold.rel_ignore", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b00);
        bus.pin_hlda = 1'b0;
        step();
        check_output("hold.idle", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b00);
        step();
        check_output("hold.rereq", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b10);
        bus.pin_hlda = 1'b1;
        bus.dma_req  = 1'b0;
        step();
        check_output("hold.withdraw", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b00);
        step();
        check_output("hold.stay_idle", {30'd0, bus.pin_hold, bus.dma_gnt}, 32'b00);
        idle_inputs();

        // Reset in REQ with a pending wait state and status loaded
        load_status(8'h42);
        bus.dma_req = 1'b1;
        step();
        check_output("pre_rst.hold",  {31'd0, bus.pin_hold}, 32'd1);
        check_output("pre_rst.ready", {31'd0, bus.pin_ready}, 32'd0);
        pin_reset_n  = 1'b0;
        bus.pin_dbin = 1'b1;
        step();
        check_reset_state("mid_rst");
        step();
        check_output("mid_rst.hold2", {31'd0, bus.pin_hold}, 32'd0);
        pin_reset_n  = 1'b1;
        bus.dma_req  = 1'b0;
        bus.pin_dbin = 1'b0;
        step();
        check_output("post_rst.f1f2", {30'd0, bus.pin_f1, bus.pin_f2}, 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
